button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the raw UP/DOWN push-buttons for the time/date field registers (hours, minutes, ...).
//  Per button: 2-flop synchronizer, debounce, then a one-cycle press pulse with optional auto-repeat.
//  Its pulses drive the registers' UP/DOWN inputs, so no register needs its own wait counter.
//  UP and DOWN are mutually exclusive: a simultaneous hold fires neither.
// PARAMETERS
//  CNT_W      26          width of the debounce/repeat counters; every count below must fit
//  DEB_CNT    1_000_000   consecutive stable cycles needed to accept a level change (10 ms at 100 MHz)
//  REP_DELAY  50_000_000  cycles from the first pulse to the first repeat pulse (500 ms)
//  REP_PERIOD 15_000_000  cycles between later repeat pulses (150 ms)
// PORTS
//  CLK         in   1  system clock, all logic on posedge
//  RESET       in   1  asynchronous, active-high reset
//  UP_in       in   1  raw UP button, asynchronous, bouncing, 1 = pressed
//  DOWN_in     in   1  raw DOWN button, same as UP_in
//  UP          out  1  one-cycle increment pulse
//  DOWN        out  1  one-cycle decrement pulse
//  UP_level    out  1  debounced UP level
//  DOWN_level  out  1  debounced DOWN level
// BEHAVIOUR
//  - Reset: sync flops, levels, counters and pulses = 0; FSMs = IDLE; all outputs 0 during RESET.
//  - Sync: s1 <= pin; s2 <= s1.
//  - Debounce counter:
//      clears whenever s2 == level;
//      increments while s2 != level;
//      at count == DEB_CNT-1 with mismatch still present, level <= s2 and counter clears.
//  - Glitch rule: a mismatch shorter than DEB_CNT cycles never changes the level.
//  - Pulses are registered.
//      Latency: if the pin goes high before edge 0 and stays high, the pulse is high for exactly
//      the one cycle after edge DEB_CNT+2.
//      Release is filtered the same way and produces no pulse.
//  - FSM per channel: IDLE, HOLD, REPEAT.
//      IDLE->HOLD on level rising; fire one pulse; clear repeat counter.
//      HOLD: count; at REP_DELAY-1 -> REPEAT, fire pulse, clear counter.
//      REPEAT: count; at REP_PERIOD-1 fire pulse, clear counter, stay.
//      Any state -> IDLE in the cycle level falls; no pulse; counter cleared.
//  - Mutual exclusion: while UP_level & DOWN_level, both pulse outputs are forced 0.
//      Both FSMs keep running; suppressed pulses are lost, not queued.
//  - Counter widths: compares are exact equality; counters never wrap; CNT_W is not checked at run time.
//  - Reset mid-hold: the channel returns to IDLE.
//      A button still held after reset release is treated as a new press:
//      pulse after DEB_CNT+2 edges.
// CONFIGURATION
//  Macro BTN_AUTOREPEAT_EN.
//   Defined: IDLE/HOLD/REPEAT behaviour as above.
//   Undefined:
//     FSM has only IDLE/HOLD; exactly one pulse per press regardless of hold time.
//     Repeat counter is not built; REP_DELAY and REP_PERIOD are ignored.
// STRUCTURE
//  Shared package btn_cond_pkg:
//    FSM state encodings (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_REPEAT=2'd2);
//    default count constants for 100 MHz.
//  Sub-module button_channel (sync + debounce + FSM, raw pulse out), instantiated twice.
//  Top level holds only the mutual-exclusion mask and the output registers.
// TESTING (bench params: DEB_CNT=4, REP_DELAY=20, REP_PERIOD=8, macro defined unless noted)
//  1 UP_in high and held from edge 0 ->
//      UP_level rises after edge 5;
//      UP pulses once after edge 6;
//      DOWN stays 0.
//  2 UP_in toggling every 2 cycles for 40 cycles, then low ->
//      UP_level stays 0; no pulse.
//  3 UP_in held 60 cycles ->
//      pulses after edges 6, 26, 34, 42, 50, 58;
//      none after release;
//      UP_level falls 6 edges after release.
//  4 UP held, DOWN_in raised at edge 10 and held ->
//      no UP or DOWN pulse while both levels are 1;
//      UP repeats resume when DOWN_level falls.
//  5 RESET asserted at edge 15 of a hold, released at 18, pin still high ->
//      outputs 0 at once;
//      new pulse after edge 18+DEB_CNT+2.
//  6 Macro undefined, UP_in held 60 cycles ->
//      exactly one pulse, after edge 6.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// btn_cond_pkg: FSM state encodings and default 100 MHz timing constants for the button conditioner
package btn_cond_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;
  localparam int DEF_CNT_W      = 26;
  localparam int DEF_DEB_CNT    = 1_000_000;
  localparam int DEF_REP_DELAY  = 50_000_000;
  localparam int DEF_REP_PERIOD = 15_000_000;
endpackage

// File: rtl/button_conditioner_channel.sv
// button_channel: sync, debounce and press pulse for one button; BTN_AUTOREPEAT_EN adds hold-to-repeat
module button_channel
  import btn_cond_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEB_CNT    = DEF_DEB_CNT,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level,
  output logic pulse
);
  logic s1_q, s1_d, s2_q, s2_d, level_q, level_d, deb_done;
  logic [CNT_W-1:0] deb_q, deb_d;
  btn_state_e state_q, state_d;

  if (DEB_CNT < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_cfg
    $error("button_channel: all counts must be at least 1");
  end

  // synchronizer shift and debounce: accept a level change only after DEB_CNT mismatched cycles
  always_comb begin
    s1_d     = pin_in;
    s2_d     = s1_q;
    deb_done = (s2_q != level_q) && (deb_q == CNT_W'(DEB_CNT - 1));
    deb_d    = (s2_q == level_q || deb_done) ? '0 : deb_q + CNT_W'(1);
    level_d  = deb_done ? s2_q : level_q;
  end

  // synchronizer, debounce counter, debounced level and FSM state registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= '0;
      level_q <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      level_q <= level_d;
      state_q <= state_d;
    end

`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0] rep_q, rep_d;

  // press fires at once, first repeat after REP_DELAY, then every REP_PERIOD; release goes idle silently
  always_comb begin
    state_d = state_q;
    rep_d   = rep_q + CNT_W'(1);
    pulse   = 1'b0;
    if (!level_q) begin
      state_d = ST_IDLE;
      rep_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_HOLD;
      rep_d   = '0;
      pulse   = 1'b1;
    end else if (state_q == ST_HOLD && rep_q == CNT_W'(REP_DELAY - 1)) begin
      state_d = ST_REPEAT;
      rep_d   = '0;
      pulse   = 1'b1;
    end else if (state_q == ST_REPEAT && rep_q == CNT_W'(REP_PERIOD - 1)) begin
      rep_d   = '0;
      pulse   = 1'b1;
    end
  end

  // repeat interval counter
  always_ff @(posedge clk or posedge rst)
    if (rst) rep_q <= '0;
    else rep_q <= rep_d;
`else
  // single pulse on the first cycle of a debounced press, nothing while held
  always_comb begin
    state_d = level_q ? ST_HOLD : ST_IDLE;
    pulse   = level_q && (state_q == ST_IDLE);
  end
`endif

  assign level = level_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced UP/DOWN press pulses with mutual exclusion; BTN_AUTOREPEAT_EN enables auto-repeat
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int DEB_CNT    = DEF_DEB_CNT,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD
) (
  input  logic CLK,
  input  logic RESET,
  input  logic UP_in,
  input  logic DOWN_in,
  output logic UP,
  output logic DOWN,
  output logic UP_level,
  output logic DOWN_level
);
  logic up_raw, dn_raw, up_lvl, dn_lvl;
  logic up_q, up_d, dn_q, dn_d;

  button_channel #(
    .CNT_W(CNT_W), .DEB_CNT(DEB_CNT), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_up (
    .clk(CLK), .rst(RESET), .pin_in(UP_in), .level(up_lvl), .pulse(up_raw)
  );

  button_channel #(
    .CNT_W(CNT_W), .DEB_CNT(DEB_CNT), .REP_DELAY(REP_DELAY), .REP_PERIOD(REP_PERIOD)
  ) u_dn (
    .clk(CLK), .rst(RESET), .pin_in(DOWN_in), .level(dn_lvl), .pulse(dn_raw)
  );

  // both buttons held means an ambiguous request: drop pulses from either side
  always_comb begin
    up_d = up_raw & ~(up_lvl & dn_lvl);
    dn_d = dn_raw & ~(up_lvl & dn_lvl);
  end

  // registered pulse outputs
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      up_q <= 1'b0;
      dn_q <= 1'b0;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
    end

  assign UP         = up_q;
  assign DOWN       = dn_q;
  assign UP_level   = up_lvl;
  assign DOWN_level = dn_lvl;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed table, corner sequences and randomized run against a behavioural model
module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk = 1'b0, rst = 1'b1, up_in = 1'b0, dn_in = 1'b0;
  logic up, dn, upl, dnl;
  int checks = 0, failures = 0;
  bit model_on = 1'b0;

  button_conditioner #(.CNT_W(8), .DEB_CNT(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .CLK(clk), .RESET(rst), .UP_in(up_in), .DOWN_in(dn_in),
    .UP(up), .DOWN(dn), .UP_level(upl), .DOWN_level(dnl)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: level flips after DEB consecutive disagreeing cycles of the 2-cycle delayed pin;
  // pulses are due at hold time 0 and, with auto-repeat, at RD, RD+RP, RD+2RP, ...
  bit m_s1[2], m_s2[2], m_lvl[2], m_out[2];
  int m_run[2], m_t[2];

  function automatic bit due(input int t);
`ifdef BTN_AUTOREPEAT_EN
    return t == 0 || (t >= RD && (t - RD) % RP == 0);
`else
    return t == 0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_out[c] = 0; m_run[c] = 0; m_t[c] = 0;
      end
    end else begin
      bit pins[2];
      bit both;
      pins[0] = up_in;
      pins[1] = dn_in;
      both = m_lvl[0] && m_lvl[1];
      for (int c = 0; c < 2; c++) begin
        bit was;
        m_out[c] = m_lvl[c] && due(m_t[c]) && !both;
        was = m_lvl[c];
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DEB) begin
            m_lvl[c] = m_s2[c];
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
        m_s2[c] = m_s1[c];
        m_s1[c] = pins[c];
        m_t[c] = (was && m_lvl[c]) ? m_t[c] + 1 : 0;
      end
    end
  end

  always @(negedge clk) if (model_on) begin
    check("model_UP", up, m_out[0]);
    check("model_DOWN", dn, m_out[1]);
    check("model_UP_level", upl, m_lvl[0]);
    check("model_DOWN_level", dnl, m_lvl[1]);
  end

  typedef struct {
    int hold; int n_pulse; int first; int last; int rise; int fall;
  } vec_t;
  vec_t tbl[7];

  task automatic settle();
    up_in = 1'b0;
    dn_in = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    int cnt, first, last, rise, fall, dcnt, bad;
`ifdef BTN_AUTOREPEAT_EN
    tbl[0] = '{3, 0, -1, -1, -1, -1};
    tbl[1] = '{4, 1, 6, 6, 5, 9};
    tbl[2] = '{10, 1, 6, 6, 5, 15};
    tbl[3] = '{21, 2, 6, 26, 5, 26};
    tbl[4] = '{27, 2, 6, 26, 5, 32};
    tbl[5] = '{29, 3, 6, 34, 5, 34};
    tbl[6] = '{60, 6, 6, 58, 5, 65};
`else
    tbl[0] = '{3, 0, -1, -1, -1, -1};
    tbl[1] = '{4, 1, 6, 6, 5, 9};
    tbl[2] = '{10, 1, 6, 6, 5, 15};
    tbl[3] = '{21, 1, 6, 6, 5, 26};
    tbl[4] = '{27, 1, 6, 6, 5, 32};
    tbl[5] = '{29, 1, 6, 6, 5, 34};
    tbl[6] = '{60, 1, 6, 6, 5, 65};
`endif
    repeat (3) @(negedge clk);
    check("reset_UP", up, 0);
    check("reset_DOWN", dn, 0);
    check("reset_UP_level", upl, 0);
    check("reset_DOWN_level", dnl, 0);
    #2;
    rst = 1'b0;
    model_on = 1'b1;
    settle();

    foreach (tbl[i]) begin
      cnt = 0; first = -1; last = -1; rise = -1; fall = -1; dcnt = 0;
      up_in = 1'b1;
      for (int e = 0; e < tbl[i].hold + 12; e++) begin
        if (e == tbl[i].hold) up_in = 1'b0;
        @(posedge clk); #1;
        if (up) begin cnt++; if (first < 0) first = e; last = e; end
        if (dn) dcnt++;
        if (upl && rise < 0) rise = e;
        if (!upl && rise >= 0 && fall < 0) fall = e;
      end
      check($sformatf("hold%0d_pulses", tbl[i].hold), cnt, tbl[i].n_pulse);
      check($sformatf("hold%0d_first", tbl[i].hold), first, tbl[i].first);
      check($sformatf("hold%0d_last", tbl[i].hold), last, tbl[i].last);
      check($sformatf("hold%0d_rise", tbl[i].hold), rise, tbl[i].rise);
      check($sformatf("hold%0d_fall", tbl[i].hold), fall, tbl[i].fall);
      check($sformatf("hold%0d_down", tbl[i].hold), dcnt, 0);
      settle();
    end

    cnt = 0; rise = 0;
    for (int e = 0; e < 50; e++) begin
      up_in = (e < 40) ? ((e / 2) % 2 == 0) : 1'b0;
      @(posedge clk); #1;
      if (up) cnt++;
      if (upl) rise++;
    end
    check("bounce_pulses", cnt, 0);
    check("bounce_level_cycles", rise, 0);
    settle();

    cnt = 0; first = 0; last = 0; dcnt = 0; bad = 0;
    up_in = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      if (e == 10) dn_in = 1'b1;
      if (e == 40) dn_in = 1'b0;
      @(posedge clk); #1;
      if (up && e < 10) cnt++;
      if (up && e >= 10 && e <= 46) bad++;
      if (up && e >= 47 && e <= 55) first++;
      if (dn) dcnt++;
      if (upl && dnl && (up || dn)) last++;
      if (e == 20) check("both_down_level_on", dnl, 1);
      if (e == 46) check("both_down_level_off", dnl, 0);
    end
    check("both_up_before", cnt, 1);
    check("both_up_masked", bad, 0);
`ifdef BTN_AUTOREPEAT_EN
    check("both_up_resume", first, 1);
`else
    check("both_up_resume", first, 0);
`endif
    check("both_down_pulses", dcnt, 0);
    check("both_pulse_while_both", last, 0);
    settle();

    cnt = 0; first = -1; rise = -1;
    up_in = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      @(posedge clk); #1;
      if (up) cnt++;
    end
    check("rst_hold_pulses", cnt, 1);
    check("rst_hold_level", upl, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_now_level", upl, 0);
    check("rst_now_outs", {up, dn, dnl}, 0);
    bad = 0;
    for (int e = 15; e <= 17; e++) begin
      @(posedge clk); #1;
      if (up || dn || upl || dnl) bad++;
    end
    check("rst_held_outs", bad, 0);
    @(negedge clk); #2;
    rst = 1'b0;
    cnt = 0;
    for (int e = 18; e <= 32; e++) begin
      @(posedge clk); #1;
      if (up) begin cnt++; if (first < 0) first = e; end
      if (upl && rise < 0) rise = e;
    end
    check("rst_new_pulses", cnt, 1);
    check("rst_new_pulse_edge", first, 24);
    check("rst_new_rise_edge", rise, 23);
    settle();

    repeat (300) begin
      int len;
      @(negedge clk); #2;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 80) : $urandom_range(1, 12);
      up_in = 1'($urandom_range(0, 1));
      dn_in = ($urandom_range(0, 3) == 0) ? up_in : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk); #2;
        rst = 1'b0;
      end
      repeat (len) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
